// File: rtl/rr_request_agent.sv
// Requester-side agent for the round-robin arbiter: per-channel pending job counters, one arbitration
// round in flight at a time, fixed BURST_LEN transfer window. Optional grant legality check: RR_AGENT_GRANT_CHECK_EN.
module rr_request_agent #(
    parameter int unsigned REQUESTERS = 4,
    parameter int unsigned PEND_DEPTH = 4,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [REQUESTERS-1:0]         job_valid,
    output logic [REQUESTERS-1:0]         job_ready,
    output logic [REQUESTERS-1:0]         request,
    input  logic [REQUESTERS-1:0]         chosen,
    output logic                          xfer_active,
    output logic [$clog2(REQUESTERS)-1:0] xfer_owner,
    output logic                          xfer_last,
    output logic                          grant_err
);

    localparam int unsigned OW = $clog2(REQUESTERS);
    localparam int unsigned CW = $clog2(PEND_DEPTH + 1);
    localparam int unsigned BW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        XFER = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [BW-1:0]           burst_q, burst_d;
    logic [CW-1:0]           cnt_q [REQUESTERS];
    logic [REQUESTERS-1:0]   pending;
    logic [REQUESTERS-1:0]   inc;
    logic [REQUESTERS-1:0]   dec;
    logic [REQUESTERS-1:0]   request_d;
    logic                    xfer_active_d;
    logic                    xfer_last_d;
    logic                    grant_err_d;
    logic [OW-1:0]           xfer_owner_d;
    logic [OW-1:0]           pick_idx;
    logic                    pick_ok;
    logic                    grant_bad;

    // Counter status: readiness is from the current count only, never a same-cycle decrement.
    always_comb begin
        for (int i = 0; i < REQUESTERS; i++) begin
            pending[i]   = (cnt_q[i] != '0);
            job_ready[i] = (cnt_q[i] < CW'(PEND_DEPTH));
            inc[i]       = job_valid[i] && job_ready[i];
        end
    end

    // Lowest set bit of the grant; equals the only bit when the grant is one-hot.
    always_comb begin
        pick_idx = '0;
        for (int i = REQUESTERS - 1; i >= 0; i--) begin
            if (chosen[i]) begin
                pick_idx = OW'(i);
            end
        end
    end

`ifdef RR_AGENT_GRANT_CHECK_EN
    localparam logic [REQUESTERS-1:0] LSB_ONE = REQUESTERS'(1);

    logic [REQUESTERS-1:0] snap_q;

    // Requests issued this round; pending only changes by increments until the grant is consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_q <= '0;
        end else if (state_q == IDLE) begin
            snap_q <= pending;
        end
    end

    assign pick_ok   = (chosen != '0) && ((chosen & (chosen - LSB_ONE)) == '0) && ((chosen & snap_q) != '0);
    assign grant_bad = (chosen != '0) && !pick_ok;
`else
    assign pick_ok   = (chosen != '0);
    assign grant_bad = 1'b0;
`endif

    // Next state and next registered outputs.
    always_comb begin
        state_d      = state_q;
        burst_d      = burst_q;
        request_d    = '0;
        xfer_owner_d = xfer_owner;
        grant_err_d  = 1'b0;
        dec          = '0;
        unique case (state_q)
            IDLE: begin
                if (pending != '0) begin
                    state_d   = REQ;
                    request_d = pending;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                state_d = IDLE;
                if (pick_ok) begin
                    state_d       = XFER;
                    burst_d       = BW'(BURST_LEN - 1);
                    xfer_owner_d  = pick_idx;
                    dec[pick_idx] = pending[pick_idx];
                end else begin
                    grant_err_d = grant_bad;
                end
            end
            XFER: begin
                if (burst_q == '0) begin
                    state_d = IDLE;
                end else begin
                    burst_d = burst_q - BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        xfer_active_d = (state_d == XFER);
        xfer_last_d   = xfer_active_d && (burst_d == '0);
        if (!xfer_active_d) begin
            xfer_owner_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            burst_q     <= '0;
            request     <= '0;
            xfer_active <= 1'b0;
            xfer_owner  <= '0;
            xfer_last   <= 1'b0;
            grant_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            request     <= request_d;
            xfer_active <= xfer_active_d;
            xfer_owner  <= xfer_owner_d;
            xfer_last   <= xfer_last_d;
            grant_err   <= grant_err_d;
        end
    end

    // Simultaneous increment and decrement cancel out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REQUESTERS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REQUESTERS; i++) begin
                if (inc[i] != dec[i]) begin
                    cnt_q[i] <= inc[i] ? (cnt_q[i] + CW'(1)) : (cnt_q[i] - CW'(1));
                end
            end
        end
    end

endmodule
